// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl -- top-level game-flow controller for the jump game.
//
// Sequences a multi-life, multi-level round structure: start screen, map
// preparation delay, idle/jump/fly/fall play states, life loss, level
// progression and an end screen. Keys are edge-detected so a held key acts
// once. A watchdog forces a life loss if the character stays airborne for
// FLY_TIMEOUT cycles.
//
// Optional feature: define GAME_PAUSE_EN to add a PAUSE state toggled by
// rising edges of key_pause while in GAME_IDLE. Without it key_pause is
// ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   key[1:0]            00 none, 01 left, 10 right, 11 spacebar
//   key_pause           pause toggle request (GAME_PAUSE_EN only)
//   jump_fail           character not standing on a block
//   time_elapsed        round time bar expired
//   character_landed    physics reports landing
//   *_en                render layer enables
//   bg_color_select     background palette select
//   jump_left/right     1-cycle jump pulses
//   timer_restart       1-cycle time bar restart pulse
//   lives_left, level   remaining lives, 0-based level
//   score               total landings, saturating
//   game_won            set in GAME_END when all levels are cleared
module game_flow_ctrl #(
    parameter int N_LIVES         = 3,
    parameter int N_LEVELS        = 4,
    parameter int JUMPS_PER_LEVEL = 8,
    parameter int PREP_CYCLES     = 16,
    parameter int FLY_TIMEOUT     = 4096,
    parameter int SCORE_W         = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         key,
    input  logic               key_pause,
    input  logic               jump_fail,
    input  logic               time_elapsed,
    input  logic               character_landed,
    output logic               start_screen_en,
    output logic               blocks_en,
    output logic               time_bar_en,
    output logic               character_en,
    output logic               points_en,
    output logic               end_screen_en,
    output logic               bg_color_select,
    output logic               jump_left,
    output logic               jump_right,
    output logic               timer_restart,
    output logic [3:0]         lives_left,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic               game_won
);

    localparam int PREP_W = $clog2(PREP_CYCLES) + 1;
    localparam int FLY_W  = $clog2(FLY_TIMEOUT);

    localparam logic [PREP_W-1:0] PREP_LAST  = PREP_W'(PREP_CYCLES - 1);
    localparam logic [FLY_W-1:0]  FLY_LAST   = FLY_W'(FLY_TIMEOUT - 1);
    localparam logic [7:0]        LAST_JUMP  = 8'(JUMPS_PER_LEVEL - 1);
    localparam logic [3:0]        LAST_LEVEL = 4'(N_LEVELS - 1);
    localparam logic [3:0]        LIVES_INIT = 4'(N_LIVES);

    typedef enum logic [3:0] {
        S_START,
        S_PREP,
        S_IDLE,
        S_JUMP_L,
        S_JUMP_R,
        S_FLY,
        S_FALL,
        S_LIFE_LOST,
        S_LEVEL_UP,
        S_END
`ifdef GAME_PAUSE_EN
        , S_PAUSE
`endif
    } state_t;

    state_t              state, state_n;
    logic [1:0]          key_q;
    logic [PREP_W-1:0]   prep_cnt, prep_n;
    logic [FLY_W-1:0]    fly_cnt, fly_n;
    logic [7:0]          jumps, jumps_n;
    logic [3:0]          lives_n, level_n;
    logic [SCORE_W-1:0]  score_n;
    logic                won_n;
    logic                key_evt;
    logic                play;
    logic                pause_evt;

    // A key acts only on the cycle it changes to a non-zero code.
    assign key_evt = (key != key_q) && (key != 2'b00);

`ifdef GAME_PAUSE_EN
    logic key_pause_q;
    always_ff @(posedge clk) begin
        if (rst) key_pause_q <= 1'b0;
        else     key_pause_q <= key_pause;
    end
    assign pause_evt = key_pause & ~key_pause_q;
`else
    logic unused_pause;
    assign unused_pause = key_pause;
    assign pause_evt    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_START;
            key_q      <= 2'b00;
            prep_cnt   <= '0;
            fly_cnt    <= '0;
            jumps      <= '0;
            lives_left <= '0;
            level      <= '0;
            score      <= '0;
            game_won   <= 1'b0;
        end else begin
            state      <= state_n;
            key_q      <= key;
            prep_cnt   <= prep_n;
            fly_cnt    <= fly_n;
            jumps      <= jumps_n;
            lives_left <= lives_n;
            level      <= level_n;
            score      <= score_n;
            game_won   <= won_n;
        end
    end

    always_comb begin
        state_n         = state;
        jumps_n         = jumps;
        lives_n         = lives_left;
        level_n         = level;
        score_n         = score;
        won_n           = game_won;
        // Delay counters run only inside their own states and sit at zero
        // everywhere else, so every entry starts a fresh count.
        prep_n          = (state == S_PREP) ? prep_cnt + 1'b1 : '0;
        fly_n           = (state == S_FLY || state == S_FALL) ? fly_cnt + 1'b1 : '0;
        play            = 1'b0;
        start_screen_en = 1'b0;
        points_en       = 1'b0;
        end_screen_en   = 1'b0;
        bg_color_select = 1'b0;
        jump_left       = 1'b0;
        jump_right      = 1'b0;
        timer_restart   = 1'b0;

        case (state)
            S_START: begin
                start_screen_en = 1'b1;
                if (key_evt && key == 2'b11) begin
                    state_n = S_PREP;
                    lives_n = LIVES_INIT;
                    level_n = '0;
                    score_n = '0;
                    jumps_n = '0;
                    won_n   = 1'b0;
                end
            end
            S_PREP: begin
                start_screen_en = 1'b1;
                if (prep_cnt == PREP_LAST) begin
                    timer_restart = 1'b1;
                    state_n       = S_IDLE;
                end
            end
            S_IDLE: begin
                play            = 1'b1;
                bg_color_select = 1'b1;
                if (jump_fail)                     state_n = S_FALL;
                else if (time_elapsed)             state_n = S_LIFE_LOST;
                else if (key_evt && key == 2'b01)  state_n = S_JUMP_L;
                else if (key_evt && key == 2'b10)  state_n = S_JUMP_R;
`ifdef GAME_PAUSE_EN
                else if (pause_evt)                state_n = S_PAUSE;
`endif
            end
            S_JUMP_L: begin
                play      = 1'b1;
                jump_left = 1'b1;
                state_n   = S_FLY;
            end
            S_JUMP_R: begin
                play       = 1'b1;
                jump_right = 1'b1;
                state_n    = S_FLY;
            end
            S_FLY: begin
                play = 1'b1;
                // Landing takes precedence over a watchdog expiry in the same cycle.
                if (character_landed) begin
                    score_n       = (&score) ? score : score + 1'b1;
                    jumps_n       = jumps + 1'b1;
                    timer_restart = 1'b1;
                    state_n       = (jumps == LAST_JUMP) ? S_LEVEL_UP : S_IDLE;
                end else if (fly_cnt == FLY_LAST) begin
                    state_n = S_LIFE_LOST;
                end
            end
            S_FALL: begin
                play = 1'b1;
                if (character_landed || fly_cnt == FLY_LAST) state_n = S_LIFE_LOST;
            end
            S_LIFE_LOST: begin
                play    = 1'b1;
                lives_n = lives_left - 4'd1;
                if (lives_left == 4'd1) begin
                    state_n = S_END;
                    won_n   = 1'b0;
                end else begin
                    state_n = S_PREP;
                end
            end
            S_LEVEL_UP: begin
                play    = 1'b1;
                jumps_n = '0;
                if (level == LAST_LEVEL) begin
                    won_n   = 1'b1;
                    state_n = S_END;
                end else begin
                    level_n = level + 4'd1;
                    state_n = S_PREP;
                end
            end
            S_END: begin
                end_screen_en = 1'b1;
                points_en     = 1'b1;
                if (key_evt && key == 2'b11) state_n = S_START;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSE: begin
                play = 1'b1;
                if (pause_evt) state_n = S_IDLE;
            end
`endif
            default: state_n = S_START;
        endcase

        blocks_en    = play;
        time_bar_en  = play;
        character_en = play;
        if (play) points_en = 1'b1;
    end

endmodule
